// File: rtl/sdram_arbiter.sv
// Arbitrates video, CPU and (optionally) loader requests onto one fixed-length SDRAM access.
// Define SDRAM_ARB_LOADER_EN to build the write-only loader port at lowest priority.
module sdram_arbiter #(
    parameter int AW         = 18,
    parameter int ACC_CYCLES = 6
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_dout,
    output logic          vid_ack,
`ifdef SDRAM_ARB_LOADER_EN
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_din,
    output logic          ld_ack,
`endif
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout,
    output logic          ram_cs,
    output logic          ram_oe,
    output logic          ram_we
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
`ifdef SDRAM_ARB_LOADER_EN
    localparam logic [1:0] OWN_LD   = 2'd3;
`endif
    localparam logic [3:0] LAST_CYC = 4'(ACC_CYCLES - 1);

    state_t        state, state_nxt;
    logic [1:0]    grant;
    logic [1:0]    owner;
    logic [3:0]    acc_cnt;
    logic [1:0]    starve_cnt;
    logic [AW-1:0] lat_addr;
    logic [7:0]    lat_din;
    logic          lat_we;

    // After two video grants in a row with the CPU waiting, the CPU jumps the queue.
    always_comb begin
        grant = OWN_NONE;
        if (cpu_req && starve_cnt == 2'd2)
            grant = OWN_CPU;
        else if (vid_req)
            grant = OWN_VID;
        else if (cpu_req)
            grant = OWN_CPU;
`ifdef SDRAM_ARB_LOADER_EN
        else if (ld_req)
            grant = OWN_LD;
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant != OWN_NONE) state_nxt = ACCESS;
            ACCESS:  if (acc_cnt == LAST_CYC) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            owner      <= OWN_NONE;
            acc_cnt    <= 4'd0;
            starve_cnt <= 2'd0;
            lat_addr   <= '0;
            lat_din    <= 8'h00;
            lat_we     <= 1'b0;
            cpu_dout   <= 8'h00;
            vid_dout   <= 8'h00;
        end else begin
            if (state == IDLE && grant != OWN_NONE) begin
                owner   <= grant;
                acc_cnt <= 4'd0;
                case (grant)
                    OWN_VID: begin
                        lat_addr <= vid_addr;
                        lat_din  <= 8'h00;
                        lat_we   <= 1'b0;
                    end
                    OWN_CPU: begin
                        lat_addr <= cpu_addr;
                        lat_din  <= cpu_din;
                        lat_we   <= cpu_we;
                    end
`ifdef SDRAM_ARB_LOADER_EN
                    OWN_LD: begin
                        lat_addr <= ld_addr;
                        lat_din  <= ld_din;
                        lat_we   <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            if (state == ACCESS) begin
                acc_cnt <= acc_cnt + 4'd1;
                if (acc_cnt == LAST_CYC && !lat_we) begin
                    if (owner == OWN_CPU) cpu_dout <= ram_dout;
                    if (owner == OWN_VID) vid_dout <= ram_dout;
                end
            end
            if (!cpu_req)
                starve_cnt <= 2'd0;
            else if (state == IDLE && grant == OWN_CPU)
                starve_cnt <= 2'd0;
            else if (state == IDLE && grant == OWN_VID)
                starve_cnt <= starve_cnt + 2'd1;
        end
    end

    // Strobes and acks decode straight from state so reset drops them on the next edge.
    always_comb begin
        ram_cs   = (state == ACCESS);
        ram_oe   = (state == ACCESS) && !lat_we;
        ram_we   = (state == ACCESS) && lat_we;
        ram_addr = lat_addr;
        ram_din  = lat_din;
        cpu_ack  = (state == DONE) && (owner == OWN_CPU);
        vid_ack  = (state == DONE) && (owner == OWN_VID);
`ifdef SDRAM_ARB_LOADER_EN
        ld_ack   = (state == DONE) && (owner == OWN_LD);
`endif
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: acks are checked against an expected queue, RAM-side cycles against a second queue.
// Loader scenarios are compiled in only when SDRAM_ARB_LOADER_EN is defined.
module tb_sdram_arbiter;

  localparam int AW  = 18;
  localparam int ACC = 6;
  localparam logic [1:0] P_VID = 2'd1;
  localparam logic [1:0] P_CPU = 2'd2;
  localparam logic [1:0] P_LD  = 2'd3;

  logic clk_sys = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [7:0] cpu_din, cpu_dout;
  logic vid_req, vid_ack;
  logic [AW-1:0] vid_addr;
  logic [7:0] vid_dout;
  logic ld_ack;
`ifdef SDRAM_ARB_LOADER_EN
  logic ld_req;
  logic [AW-1:0] ld_addr;
  logic [7:0] ld_din;
`else
  assign ld_ack = 1'b0;
`endif
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic ram_cs, ram_oe, ram_we;

  logic fixed_en;
  logic [7:0] fixed_val;
  assign ram_dout = fixed_en ? fixed_val : (ram_addr[7:0] ^ 8'hC3);

  sdram_arbiter #(.AW(AW), .ACC_CYCLES(ACC)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
`ifdef SDRAM_ARB_LOADER_EN
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
`endif
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we)
  );

  // clock / cycle count
  always #5 clk_sys = ~clk_sys;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0]  exp_q[$];
  logic [26:0] ram_q[$];
  logic [7:0]  exp_cpu_dout = 8'h00;
  logic [7:0]  exp_vid_dout = 8'h00;
  int          cs_len = 0;
  logic [26:0] cur_ram = '0;
  bit          cur_valid = 1'b0;
  bit          abort_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_read(input logic [1:0] port, input logic [AW-1:0] addr, input logic [7:0] data);
    exp_q.push_back({port, data});
    ram_q.push_back({1'b0, addr, 8'h00});
    if (port == P_CPU) exp_cpu_dout = data;
    if (port == P_VID) exp_vid_dout = data;
  endtask

  task automatic push_write(input logic [1:0] port, input logic [AW-1:0] addr, input logic [7:0] data);
    exp_q.push_back({port, exp_cpu_dout});
    ram_q.push_back({1'b1, addr, data});
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(output int c, output logic [1:0] who);
    bit timed_out;
    timed_out = 1'b1;
    c = -1;
    who = 2'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (vid_ack || cpu_ack || ld_ack) begin
        c = cyc;
        who = vid_ack ? P_VID : (cpu_ack ? P_CPU : P_LD);
        timed_out = 1'b0;
        break;
      end
    end
    check("ack_timeout", 32'(timed_out), 32'd0);
  endtask

  // monitor: acks against exp_q, RAM-side bus against ram_q
  always @(negedge clk_sys) begin
    int n;
    logic [9:0] obs;
    if (!reset) begin
      n = int'(vid_ack) + int'(cpu_ack) + int'(ld_ack);
      if (n != 0) begin
        check("ack_exclusive", n, 1);
        obs = vid_ack ? {P_VID, vid_dout} : (cpu_ack ? {P_CPU, cpu_dout} : {P_LD, cpu_dout});
        if (exp_q.size() == 0) check("ack_unexpected", exp_q.size(), 1);
        else check("ack_port_dout", obs, exp_q.pop_front());
      end
    end
    if (ram_cs) begin
      if (cs_len == 0) begin
        if (ram_q.size() == 0) begin
          check("cs_unexpected", ram_q.size(), 1);
          cur_valid = 1'b0;
        end else begin
          cur_ram = ram_q.pop_front();
          cur_valid = 1'b1;
        end
      end
      if (cur_valid)
        check("ram_bus", {ram_we, ram_oe, ram_addr, (ram_we ? ram_din : 8'h00)},
              {cur_ram[26], ~cur_ram[26], cur_ram[25:8], cur_ram[7:0]});
      cs_len++;
    end else begin
      check("strobes_idle", {ram_oe, ram_we}, 0);
      if (cs_len != 0) begin
        if (abort_pending) check("cs_len_abort", cs_len, 3);
        else check("cs_len", cs_len, ACC);
        abort_pending = 1'b0;
        cs_len = 0;
      end
    end
  end

  // stimulus
  initial begin
    int rc, c;
    int cs[6];
    logic [1:0] who;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
    vid_req = 1'b0; vid_addr = '0;
`ifdef SDRAM_ARB_LOADER_EN
    ld_req = 1'b0; ld_addr = '0; ld_din = 8'h00;
`endif
    fixed_en = 1'b0; fixed_val = 8'h00;
    repeat (3) tick();
    @(negedge clk_sys);
    check("rst_strobes_acks", {ram_cs, ram_oe, ram_we, cpu_ack, vid_ack, ld_ack}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_douts", {cpu_dout, vid_dout}, 0);
    tick();
    reset = 1'b0;
    tick();

    // CPU read 0x01234 returning 0xA5
    fixed_en = 1'b1; fixed_val = 8'hA5;
    push_read(P_CPU, 18'h01234, 8'hA5);
    cpu_we = 1'b0; cpu_addr = 18'h01234; cpu_req = 1'b1; rc = cyc;
    wait_ack(c, who);
    check("cpu_read_latency", c - rc, ACC + 1);
    tick(); cpu_req = 1'b0;

    // video read 0x2ABCD -> 0xCD^0xC3 = 0x0E
    fixed_en = 1'b0;
    push_read(P_VID, 18'h2ABCD, 8'h0E);
    vid_addr = 18'h2ABCD; vid_req = 1'b1; rc = cyc;
    wait_ack(c, who);
    check("vid_read_latency", c - rc, ACC + 1);
    tick(); vid_req = 1'b0;

    // CPU write leaves cpu_dout at 0xA5
    push_write(P_CPU, 18'h1FFFF, 8'h77);
    cpu_we = 1'b1; cpu_addr = 18'h1FFFF; cpu_din = 8'h77; cpu_req = 1'b1;
    wait_ack(c, who);
    tick(); cpu_req = 1'b0;

    // request dropped and inputs changed mid-access: 0x0F^0xC3 = 0xCC
    push_read(P_CPU, 18'h00F0F, 8'hCC);
    cpu_we = 1'b0; cpu_addr = 18'h00F0F; cpu_req = 1'b1; rc = cyc;
    tick(); tick();
    cpu_req = 1'b0; cpu_addr = 18'h3FFFF; cpu_we = 1'b1; cpu_din = 8'hEE;
    wait_ack(c, who);
    check("dropped_req_latency", c - rc, ACC + 1);
    tick(); cpu_we = 1'b0;

    // starvation guard: V V C V V C, video 0x55^0xC3 = 0x96, CPU 0xAA^0xC3 = 0x69
    push_read(P_VID, 18'h00155, 8'h96);
    push_read(P_VID, 18'h00155, 8'h96);
    push_read(P_CPU, 18'h000AA, 8'h69);
    push_read(P_VID, 18'h00155, 8'h96);
    push_read(P_VID, 18'h00155, 8'h96);
    push_read(P_CPU, 18'h000AA, 8'h69);
    vid_addr = 18'h00155; cpu_addr = 18'h000AA; vid_req = 1'b1; cpu_req = 1'b1;
    for (int i = 0; i < 6; i++) wait_ack(cs[i], who);
    tick(); vid_req = 1'b0; cpu_req = 1'b0;
    for (int i = 1; i < 6; i++) check("starve_ack_gap", cs[i] - cs[i-1], ACC + 2);

`ifdef SDRAM_ARB_LOADER_EN
    // loader write 0x3C to 0x00010, cpu_dout stays 0x69
    push_write(P_LD, 18'h00010, 8'h3C);
    ld_addr = 18'h00010; ld_din = 8'h3C; ld_req = 1'b1;
    wait_ack(c, who);
    tick(); ld_req = 1'b0;

    // all three at once: video, CPU, loader
    push_read(P_VID, 18'h00155, 8'h96);
    push_read(P_CPU, 18'h000AA, 8'h69);
    push_write(P_LD, 18'h00020, 8'h11);
    ld_addr = 18'h00020; ld_din = 8'h11;
    vid_req = 1'b1; cpu_req = 1'b1; ld_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(cs[i], who);
      tick();
      case (who)
        P_VID: vid_req = 1'b0;
        P_CPU: cpu_req = 1'b0;
        default: ld_req = 1'b0;
      endcase
    end
    vid_req = 1'b0; cpu_req = 1'b0; ld_req = 1'b0;
    for (int i = 1; i < 3; i++) check("all_ports_ack_gap", cs[i] - cs[i-1], ACC + 2);
`endif

    // reset on the 3rd access cycle of a CPU read, then re-grant
    fixed_en = 1'b1; fixed_val = 8'h5E;
    ram_q.push_back({1'b0, 18'h00321, 8'h00});
    abort_pending = 1'b1;
    cpu_we = 1'b0; cpu_addr = 18'h00321; cpu_req = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    @(negedge clk_sys);
    check("abort_cs_before", ram_cs, 1);
    tick();
    @(negedge clk_sys);
    check("abort_cs_dropped", ram_cs, 0);
    check("abort_no_ack", cpu_ack, 0);
    check("abort_cpu_dout", cpu_dout, 0);
    exp_cpu_dout = 8'h00;
    tick();
    reset = 1'b0; rc = cyc;
    push_read(P_CPU, 18'h00321, 8'h5E);
    wait_ack(c, who);
    check("post_reset_latency", c - rc, ACC + 1);
    tick(); cpu_req = 1'b0;

    repeat (5) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("ram_q_drained", ram_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 18: address width of all ports.
REQ-002 SHALL have parameter ACC_CYCLES, default 6, legal range 2..15: clk_sys cycles ram_cs is held per access.
REQ-003 SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in AW, cpu_din in 8, cpu_dout out 8, cpu_ack out 1: CPU read/write port.
REQ-006 SHALL have ports vid_req in 1, vid_addr in AW, vid_dout out 8, vid_ack out 1: video fetch port (read-only).
REQ-007 SHALL have ports ld_req in 1, ld_addr in AW, ld_din in 8, ld_ack out 1: loader port (write-only, conditional per REQ-027).
REQ-008 SHALL have ports ram_addr out AW, ram_din out 8, ram_dout in 8, ram_cs out 1, ram_oe out 1, ram_we out 1: SDRAM controller side.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-010 In IDLE, SHALL sample requests each cycle; if any is pending, latch the winner's address, data and direction, record its owner, and enter ACCESS next cycle.
REQ-011 Priority SHALL be video > CPU > loader, except per REQ-012.
REQ-012 Starvation guard: SHALL count consecutive video grants while cpu_req is pending; at a count of 2, CPU SHALL win the next arbitration; the count SHALL clear on any CPU grant or when cpu_req is low.
REQ-013 In ACCESS, SHALL assert ram_cs for exactly ACC_CYCLES cycles, with ram_oe=~write and ram_we=write; ram_addr/ram_din SHALL be stable from latched values throughout.
REQ-014 On the last ACCESS cycle, SHALL capture ram_dout into the owner's dout register on reads, then enter DONE.
REQ-015 In DONE, SHALL pulse the owner's ack for one cycle with all ram_* strobes low, then return to IDLE.
REQ-016 Latency: a request sampled in IDLE at cycle N SHALL give ram_cs high at cycles N+1..N+ACC_CYCLES and ack at N+ACC_CYCLES+1; minimum spacing between grants is ACC_CYCLES+2 cycles.
REQ-017 Requesters SHALL hold req until ack; a requester that still has req high in the cycle after its ack SHALL be treated as issuing a new request.
REQ-018 A req deasserted mid-access SHALL NOT abort it; the access completes and ack still pulses.
REQ-019 cpu_dout/vid_dout SHALL hold their value until that port's next read completes; writes SHALL NOT alter them.
REQ-020 Simultaneous requests on all ports SHALL be served one per grant in priority order; no two ack outputs SHALL ever be high in the same cycle.
REQ-021 Inputs changed during ACCESS SHALL NOT affect the access in progress.

Reset
REQ-022 While reset is high, at the next edge SHALL enter IDLE with ram_cs=ram_oe=ram_we=0, ram_addr=0, ram_din=0, all acks 0, cpu_dout=vid_dout=8'h00, starvation count 0.
REQ-023 Reset mid-ACCESS SHALL drop ram_cs on the next edge; no ack SHALL be issued for the aborted access.
REQ-024 The first arbitration SHALL occur in the first cycle after reset is low.

Configuration
REQ-025 Macro SDRAM_ARB_LOADER_EN SHALL control the loader port.
REQ-026 With SDRAM_ARB_LOADER_EN defined, the loader SHALL participate at lowest priority per REQ-011.
REQ-027 Without it, ld_* ports SHALL be absent, no loader logic SHALL be built, and arbitration SHALL be video > CPU with REQ-012 unchanged.

Verification
REQ-028 CPU read at 0x01234, ram_dout=0xA5, ACC_CYCLES=6 -> ram_cs high 6 cycles, ram_oe=1, cpu_ack at request+7, cpu_dout=0xA5.
REQ-029 vid_req, cpu_req, ld_req raised in the same cycle, all held -> order video, CPU, loader; acks 8 cycles apart; never two acks together.
REQ-030 vid_req held continuously with cpu_req pending -> video, video, CPU, video, video, CPU pattern.
REQ-031 Loader write 0x3C to 0x00010 -> ram_we=1, ram_oe=0, ram_din=0x3C, ram_addr=0x00010 for all 6 cs cycles; ld_ack pulses once; cpu_dout unchanged.
REQ-032 Reset asserted on 3rd ACCESS cycle of a CPU read -> ram_cs low next edge, no cpu_ack, cpu_dout=0x00; request granted again after reset.
REQ-033 Build without SDRAM_ARB_LOADER_EN -> no ld_* ports present; REQ-028 and REQ-030 pass.
